// File: rtl/decode_pkg.sv
// decode_pkg
// Shared definitions for the decode stage: opcode encodings, instruction
// field bit positions, register-address width and the instruction width.
// Imported by instr_fields and decode_stage.
package decode_pkg;

    localparam int REG_W   = 3;
    localparam int INSTR_W = 16;

    // Opcode encodings (instruction bits [15:13]).
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    // Field positions (LSB of each field).
    localparam int OP_LSB      = 13;
    localparam int RA_LSB      = 10;
    localparam int RB_LSB      = 7;
    localparam int RC_LSB      = 0;
    localparam int IMM7_W      = 7;
    localparam int IMM10_W     = 10;
    localparam int IMM10_SHIFT = 6;

    typedef logic [REG_W-1:0] reg_addr_t;

endpackage

// File: rtl/instr_fields.sv
// instr_fields
// Purely combinational field decoder for one instruction word.
// Ports:
//   instr  in  16  raw instruction word
//   op     out 3   opcode
//   src0   out 3   first register-file read address (0 when unused)
//   src1   out 3   second register-file read address (0 when unused)
//   dest   out 3   destination register (0 for sw/beq)
//   wen    out 1   register write enable (destination nonzero)
//   imm    out 16  extended immediate for this opcode
module instr_fields
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [2:0]         op,
    output reg_addr_t          src0,
    output reg_addr_t          src1,
    output reg_addr_t          dest,
    output logic               wen,
    output logic [INSTR_W-1:0] imm
);

    reg_addr_t          ra;
    reg_addr_t          rb;
    reg_addr_t          rc;
    logic [INSTR_W-1:0] imm7_ext;
    logic [INSTR_W-1:0] imm10_ext;

    always_comb begin
        op        = instr[OP_LSB +: 3];
        ra        = instr[RA_LSB +: REG_W];
        rb        = instr[RB_LSB +: REG_W];
        rc        = instr[RC_LSB +: REG_W];
        imm7_ext  = {{(INSTR_W-IMM7_W){instr[IMM7_W-1]}}, instr[IMM7_W-1:0]};
        imm10_ext = {instr[IMM10_W-1:0], {IMM10_SHIFT{1'b0}}};

        src0 = '0;
        src1 = '0;
        dest = '0;
        imm  = '0;

        case (op)
            OP_ADD, OP_NAND: begin
                src0 = rb;
                src1 = rc;
                dest = ra;
            end
            OP_ADDI, OP_LW, OP_JALR: begin
                src0 = rb;
                dest = ra;
                imm  = imm7_ext;
            end
            OP_SW, OP_BEQ: begin
                // rA is a source here (store data / compare operand).
                src0 = rb;
                src1 = ra;
                imm  = imm7_ext;
            end
            OP_LUI: begin
                dest = ra;
                imm  = imm10_ext;
            end
            default: begin
                src0 = '0;
            end
        endcase

        // r0 is hardwired, so a write to it is suppressed.
        wen = (dest != '0);
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// One-cycle decode pipeline stage between fetch and execute. Register-file
// read addresses are issued combinationally so read data, registered on the
// same edge as the decoded instruction, lines up with out_valid.
//
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1;
// a producer holds valid and payload stable until that transfer, and ready
// may depend combinationally on valid-independent state only.
//
// Optional feature macro: DECODE_INTERLOCK_EN (load-use interlock). When
// undefined, ex_load_* are ignored and no stall is ever generated.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_instr/in_pc      fetch-side instruction and word PC
//   in_ready                     decode accepts this cycle
//   flush                        discard held and incoming instruction
//   raddr0/raddr1                register-file read addresses
//   ex_load_valid/ex_load_dest   load in execute and its destination
//   out_valid/out_ready          decoded-instruction handshake
//   out_op/out_dest/out_wen      opcode, destination, write enable
//   out_imm/out_pc/out_instr     immediate, PC, raw instruction
module decode_stage
    import decode_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [INSTR_W-1:0] in_pc,
    output logic               in_ready,
    input  logic               flush,
    output reg_addr_t          raddr0,
    output reg_addr_t          raddr1,
    input  logic               ex_load_valid,
    input  reg_addr_t          ex_load_dest,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_op,
    output reg_addr_t          out_dest,
    output logic               out_wen,
    output logic [INSTR_W-1:0] out_imm,
    output logic [INSTR_W-1:0] out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    // Decode of the incoming word.
    logic [2:0]         in_op;
    reg_addr_t          in_src0;
    reg_addr_t          in_src1;
    reg_addr_t          in_dest;
    logic               in_wen;
    logic [INSTR_W-1:0] in_imm;

    // Decode of the held word; only its sources are needed.
    logic [2:0]         unused_held_op;
    reg_addr_t          held_src0;
    reg_addr_t          held_src1;
    reg_addr_t          unused_held_dest;
    logic               unused_held_wen;
    logic [INSTR_W-1:0] unused_held_imm;

    logic               out_valid_q, out_valid_d;
    logic [2:0]         out_op_q,    out_op_d;
    reg_addr_t          out_dest_q,  out_dest_d;
    logic               out_wen_q,   out_wen_d;
    logic [INSTR_W-1:0] out_imm_q,   out_imm_d;
    logic [INSTR_W-1:0] out_pc_q,    out_pc_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;

    logic adv;
    logic stall;
    logic accept;

    instr_fields u_in_fields (
        .instr (in_instr),
        .op    (in_op),
        .src0  (in_src0),
        .src1  (in_src1),
        .dest  (in_dest),
        .wen   (in_wen),
        .imm   (in_imm)
    );

    instr_fields u_held_fields (
        .instr (out_instr_q),
        .op    (unused_held_op),
        .src0  (held_src0),
        .src1  (held_src1),
        .dest  (unused_held_dest),
        .wen   (unused_held_wen),
        .imm   (unused_held_imm)
    );

`ifdef DECODE_INTERLOCK_EN
    // Unused sources decode to 0, so comparing against both addresses
    // only matches registers the instruction really reads.
    assign stall = ex_load_valid && (ex_load_dest != '0) &&
                   ((ex_load_dest == in_src0) || (ex_load_dest == in_src1));
`else
    logic unused_ex_load;
    assign unused_ex_load = ex_load_valid ^ (^ex_load_dest);
    assign stall = 1'b0;
`endif

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !stall && !flush;
    assign accept   = in_valid && in_ready;

    // While holding, re-read the held instruction's registers so the
    // register-file output stays consistent with out_*.
    assign raddr0 = adv ? in_src0 : held_src0;
    assign raddr1 = adv ? in_src1 : held_src1;

    always_comb begin
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_dest_d  = out_dest_q;
        out_wen_d   = out_wen_q;
        out_imm_d   = out_imm_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;

        if (flush) begin
            out_valid_d = 1'b0;
            out_wen_d   = 1'b0;
            out_instr_d = NOP_INSTR;
        end else if (adv) begin
            if (accept) begin
                out_valid_d = 1'b1;
                out_op_d    = in_op;
                out_dest_d  = in_dest;
                out_wen_d   = in_wen;
                out_imm_d   = in_imm;
                out_pc_d    = in_pc;
                out_instr_d = in_instr;
            end else begin
                // Bubble: nothing accepted, present a harmless NOP.
                out_valid_d = 1'b0;
                out_wen_d   = 1'b0;
                out_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_dest_q  <= '0;
            out_wen_q   <= 1'b0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            out_instr_q <= NOP_INSTR;
        end else begin
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_dest_q  <= out_dest_d;
            out_wen_q   <= out_wen_d;
            out_imm_q   <= out_imm_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_dest  = out_dest_q;
    assign out_wen   = out_wen_q;
    assign out_imm   = out_imm_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Directed bench for decode_stage. Expected decoded records are pushed into
// exp_q at issue time; a monitor pops and compares on every output transfer.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic [2:0]  raddr0;
    logic [2:0]  raddr1;
    logic        ex_load_valid;
    logic [2:0]  ex_load_dest;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [2:0]  out_dest;
    logic        out_wen;
    logic [15:0] out_imm;
    logic [15:0] out_pc;
    logic [15:0] out_instr;

    int checks;
    int failures;

    // {op, dest, wen, imm, pc, instr}
    logic [54:0] exp_q[$];

`ifdef DECODE_INTERLOCK_EN
    localparam bit INTERLOCK = 1'b1;
`else
    localparam bit INTERLOCK = 1'b0;
`endif

    decode_stage #(.NOP_INSTR(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_ready      (in_ready),
        .flush         (flush),
        .raddr0        (raddr0),
        .raddr1        (raddr1),
        .ex_load_valid (ex_load_valid),
        .ex_load_dest  (ex_load_dest),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op        (out_op),
        .out_dest      (out_dest),
        .out_wen       (out_wen),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .out_instr     (out_instr)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [54:0] mk(input logic [2:0] op, input logic [2:0] dest,
                                       input logic wen, input logic [15:0] imm,
                                       input logic [15:0] pc, input logic [15:0] instr);
        return {op, dest, wen, imm, pc, instr};
    endfunction

    // Present one instruction, wait (bounded) for acceptance, check the read
    // addresses issued in the accepting cycle, optionally queue the result.
    task automatic issue(input logic [15:0] instr, input logic [15:0] pc,
                         input logic [2:0] r0, input logic [2:0] r1,
                         input logic [54:0] exp, input bit push);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: got in_ready=0 want 1 instr=%0h", instr);
        end else begin
            chk("issue_raddr0", raddr0, r0);
            chk("issue_raddr1", raddr1, r1);
            if (push) exp_q.push_back(exp);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got instr=%0h want none", out_instr);
            end else begin
                chk("out_fields",
                    {out_op, out_dest, out_wen, out_imm, out_pc, out_instr},
                    exp_q.pop_front());
            end
        end
    end

    // ---------------- directed vectors ----------------
    logic [15:0] v_instr[8] = '{16'h0502, 16'h6FFF, 16'h257F, 16'h0184,
                                16'h5707, 16'hA8C0, 16'hC505, 16'hFD80};
    logic [2:0]  v_r0[8]    = '{3'd2, 3'd0, 3'd2, 3'd3, 3'd6, 3'd1, 3'd2, 3'd3};
    logic [2:0]  v_r1[8]    = '{3'd2, 3'd0, 3'd0, 3'd4, 3'd7, 3'd0, 3'd1, 3'd0};
    logic [2:0]  v_op[8]    = '{3'd0, 3'd3, 3'd1, 3'd0, 3'd2, 3'd5, 3'd6, 3'd7};
    logic [2:0]  v_dest[8]  = '{3'd1, 3'd3, 3'd1, 3'd0, 3'd5, 3'd2, 3'd0, 3'd7};
    logic        v_wen[8]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] v_imm[8]   = '{16'h0000, 16'hFFC0, 16'hFFFF, 16'h0000,
                                16'h0000, 16'hFFC0, 16'h0005, 16'h0000};

    initial begin
        bit acc;
        checks   = 0;
        failures = 0;

        rst_n         = 1'b1;
        in_valid      = 1'b0;
        in_instr      = 16'h0502;
        in_pc         = 16'h0000;
        flush         = 1'b0;
        ex_load_valid = 1'b0;
        ex_load_dest  = 3'd0;
        out_ready     = 1'b1;
        #1 rst_n = 1'b0;
        #2;

        // Reset state; read addresses follow in_instr during reset.
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_wen",   out_wen,   0);
        chk("rst_out_op",    out_op,    0);
        chk("rst_out_dest",  out_dest,  0);
        chk("rst_out_imm",   out_imm,   0);
        chk("rst_out_pc",    out_pc,    0);
        chk("rst_out_instr", out_instr, 16'h0000);
        chk("rst_raddr0",    raddr0,    2);
        chk("rst_raddr1",    raddr1,    2);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Decode of every opcode, back-to-back with out_ready=1.
        for (int i = 0; i < 8; i++) begin
            issue(v_instr[i], 16'h0010 + 16'(i), v_r0[i], v_r1[i],
                  mk(v_op[i], v_dest[i], v_wen[i], v_imm[i], 16'h0010 + 16'(i), v_instr[i]), 1'b1);
            if (i == 0) begin
                @(negedge clk);
                chk("add_out_valid", out_valid, 1);
                chk("add_out_dest",  out_dest,  1);
                chk("add_out_wen",   out_wen,   1);
            end
        end

        // Hold sw r4,r5 for 3 cycles while another instruction waits.
        settle();
        out_ready = 1'b0;
        issue(16'h9283, 16'h0020, 3'd5, 3'd4,
              mk(3'd4, 3'd0, 1'b0, 16'h0003, 16'h0020, 16'h9283), 1'b1);
        in_valid = 1'b1;
        in_instr = 16'h0502;
        in_pc    = 16'h0021;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_instr", out_instr, 16'h9283);
            chk("hold_out_imm",   out_imm,   16'h0003);
            chk("hold_out_pc",    out_pc,    16'h0020);
            chk("hold_out_wen",   out_wen,   0);
            chk("hold_raddr0",    raddr0,    5);
            chk("hold_raddr1",    raddr1,    4);
            chk("hold_in_ready",  in_ready,  0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        issue(16'h0502, 16'h0021, 3'd2, 3'd2,
              mk(3'd0, 3'd1, 1'b1, 16'h0000, 16'h0021, 16'h0502), 1'b1);

        // Load-use: add r1,r2,r3 while a load to r2 is in execute.
        settle();
        in_valid      = 1'b1;
        in_instr      = 16'h0503;
        in_pc         = 16'h0030;
        ex_load_valid = 1'b1;
        ex_load_dest  = 3'd2;
        exp_q.push_back(mk(3'd0, 3'd1, 1'b1, 16'h0000, 16'h0030, 16'h0503));
        @(negedge clk);
        chk("loaduse_in_ready", in_ready, INTERLOCK ? 0 : 1);
        acc = in_ready;
        @(posedge clk); #1;
        ex_load_valid = 1'b0;
        if (acc) in_valid = 1'b0;
        @(negedge clk);
        chk("loaduse_out_valid", out_valid, INTERLOCK ? 0 : 1);
        if (!acc) begin
            chk("loaduse_retry_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end

        // Flush a held jalr (wen=1) together with an incoming instruction.
        settle();
        out_ready = 1'b0;
        issue(16'hFD80, 16'h0040, 3'd3, 3'd0, '0, 1'b0);
        @(negedge clk);
        chk("preflush_out_valid", out_valid, 1);
        chk("preflush_out_wen",   out_wen,   1);
        @(posedge clk); #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'h0502;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_wen",   out_wen,   0);

        // Reset pulsed while holding add r1,r2,r2 under a stall.
        issue(16'h0502, 16'h0050, 3'd2, 3'd2, '0, 1'b0);
        in_valid = 1'b1;
        in_instr = 16'h0184;
        in_pc    = 16'h0051;
        @(negedge clk);
        chk("prerst_out_valid", out_valid, 1);
        chk("prerst_in_ready",  in_ready,  0);
        chk("prerst_raddr0",    raddr0,    2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_wen",   out_wen,   0);
        chk("midrst_out_op",    out_op,    0);
        chk("midrst_out_dest",  out_dest,  0);
        chk("midrst_out_imm",   out_imm,   0);
        chk("midrst_out_pc",    out_pc,    0);
        chk("midrst_out_instr", out_instr, 16'h0000);
        chk("midrst_raddr0",    raddr0,    3);
        chk("midrst_raddr1",    raddr1,    4);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready",  in_ready,  1);
        chk("postrst_out_valid", out_valid, 0);
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter NOP_INSTR, 16'h0000, instruction word reported on out_instr while out_valid=0.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid / in_instr / in_pc  in  1/16/16  fetch-side instruction, word address.
REQ-005 in_ready  out  1  decode accepts in_instr this cycle when in_valid=1 and in_ready=1.
REQ-006 flush  in  1  discards held and incoming instruction (branch redirect).
REQ-007 raddr0 / raddr1  out  3/3  register-file read addresses; read data returns one cycle later.
REQ-008 ex_load_valid / ex_load_dest  in  1/3  load currently in execute and its destination.
REQ-009 out_valid  out  1  decoded instruction valid; aligned with register-file read data.
REQ-010 out_ready  in  1  execute consumes when out_valid=1 and out_ready=1.
REQ-011 out_op / out_dest / out_wen  out  3/3/1  opcode, destination register, register write enable.
REQ-012 out_imm / out_pc / out_instr  out  16/16/16  extended immediate, PC, raw instruction.

Function
REQ-013 Field decode: op=[15:13]; rA=[12:10]; rB=[9:7]; rC=[2:0]; imm7=[6:0] sign-extended to 16 bits; imm10=[9:0] placed at bits [15:6] with zero fill.
REQ-014 Opcodes: 0 add, 1 addi, 2 nand, 3 lui, 4 sw, 5 lw, 6 beq, 7 jalr.
REQ-015 Sources: add/nand raddr0=rB, raddr1=rC; addi/lw/jalr raddr0=rB, raddr1=0; sw/beq raddr0=rB, raddr1=rA; lui both 0.
REQ-016 Destination rA for add/addi/nand/lui/lw/jalr; out_wen=1 only when that destination is nonzero; sw/beq out_wen=0, out_dest=0.
REQ-017 out_imm: lui imm10 form; addi/lw/sw/beq/jalr imm7 form; add/nand 0.
REQ-018 Latency one cycle: instruction accepted at edge T appears on out_* from T until consumed, matching read data registered at edge T.
REQ-019 Advance condition adv = !out_valid or out_ready; in_ready = adv and !stall.
REQ-020 When adv=0, raddr0/raddr1 drive the sources of the held output instruction, so read data is refreshed with the same registers.
REQ-021 When adv=1, raddr0/raddr1 drive sources decoded combinationally from in_instr.
REQ-022 On an edge with adv=1 and in_valid=1 and in_ready=1, output registers load the decoded instruction and out_valid becomes 1.
REQ-023 On an edge with adv=1 and no accept, out_valid becomes 0, out_instr becomes NOP_INSTR and out_wen becomes 0.
REQ-024 Flush has priority over everything: at the edge, out_valid becomes 0 and out_wen becomes 0; in_ready=0 while flush=1.
REQ-025 out_* are stable while out_valid=1 and out_ready=0.

Reset
REQ-026 While rst_n=0: out_valid=0, out_wen=0, out_op=0, out_dest=0, out_imm=0, out_pc=0, out_instr=NOP_INSTR; raddr0/raddr1 decode from in_instr per REQ-021.
REQ-027 Reset asserted mid-stall discards the held instruction; after release in_ready=1 on the first cycle.

Configuration
REQ-028 DECODE_INTERLOCK_EN defined: stall=1 when ex_load_valid=1, ex_load_dest!=0, and ex_load_dest equals a nonzero source used by in_instr (REQ-015); each stall inserts one bubble (REQ-023).
REQ-029 DECODE_INTERLOCK_EN undefined: stall is constant 0; ex_load_* are ignored; software schedules load-use gaps.

Structure
REQ-030 Shared package holds opcode constants (OP_ADD..OP_JALR), field bit positions, and the register-address width of 3.
REQ-031 Single sub-module instr_fields: combinational decoder from instruction word to sources, destination, wen and immediate; instantiated twice, once for in_instr and once for the held output instruction.

Verification
REQ-032 Verification: reset release, in_valid=1 with in_instr=16'h0502 (add r1,r2,r2) -> next cycle out_valid=1, out_dest=1, out_wen=1, and previous-cycle raddr0=2, raddr1=2.
REQ-033 Verification: lui r3 with imm10=10'h3FF -> out_imm=16'hFFC0, raddr0=0, raddr1=0.
REQ-034 Verification: addi with imm7=7'h7F -> out_imm=16'hFFFF; add with rA=0 -> out_wen=0.
REQ-035 Verification: out_ready=0 for 3 cycles while holding sw r4,r5 -> out_* stable, raddr0=5, raddr1=4 each stalled cycle, in_ready=0.
REQ-036 Verification: interlock enabled, ex_load_valid=1 and ex_load_dest=2 with in_instr add r1,r2,r3 -> in_ready=0 for one cycle and one bubble (out_valid=0); with the macro undefined, no bubble.
REQ-037 Verification: flush asserted with out_valid=1 and out_ready=0 -> next cycle out_valid=0 and out_wen=0; rst_n pulsed mid-stall -> all outputs at reset values immediately.
